// File: rtl/seed_loader.sv
// seed_loader: writes the selected Game of Life seed pattern into the grid memory one row at a time.
module seed_loader #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int ROW_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       key,
    input  logic             key_valid,
    input  logic             start,
    input  logic             row_ready,
    output logic             row_we,
    output logic [ROW_W-1:0] row_addr,
    output logic [COLS-1:0]  row_data,
    output logic             busy,
    output logic             load_done,
    output logic             seed_err,
    output logic [2:0]       seed_id
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t           state_q, state_d;
    logic             row_we_q, row_we_d;
    logic [ROW_W-1:0] row_addr_q, row_addr_d;
    logic [COLS-1:0]  row_data_q, row_data_d;
    logic             busy_q, busy_d;
    logic             load_done_q, load_done_d;
    logic             seed_err_q, seed_err_d;
    logic [2:0]       seed_id_q, seed_id_d;
    logic [2:0]       key_seed;
    logic             key_ok;
    logic             last_row;

    // Seeds live in columns 0-3 of the listed rows; every other row is empty.
    function automatic logic [COLS-1:0] pattern(input logic [2:0] s, input logic [ROW_W-1:0] r);
        int         ri;
        logic [3:0] p;
        ri = int'(r);
        p = (s == 3'd1) ? ((ri == 2) ? 4'hE : 4'h0) :
            (s == 3'd2) ? ((ri == 1) ? 4'h2 : (ri == 2) ? 4'h4 : (ri == 3) ? 4'h7 : 4'h0) :
            (s == 3'd3) ? ((ri == 1 || ri == 2) ? 4'h6 : 4'h0) :
            (s == 3'd4) ? ((ri == 3) ? 4'hC : (ri == 4) ? 4'h6 : (ri == 5) ? 4'h4 : 4'h0) :
            4'h0;
        return {{(COLS-4){1'b0}}, p};
    endfunction

    always_comb begin
        key_seed = (key == 4'b0001) ? 3'd1 :
                   (key == 4'b0010) ? 3'd2 :
                   (key == 4'b0100) ? 3'd3 :
                   (key == 4'b1000) ? 3'd4 : 3'd0;
        key_ok   = key_valid && (key_seed != 3'd0);
        last_row = (row_addr_q == ROW_W'(ROWS - 1));
    end

    always_comb begin
        state_d     = state_q;
        row_we_d    = row_we_q;
        row_addr_d  = row_addr_q;
        row_data_d  = row_data_q;
        busy_d      = busy_q;
        load_done_d = 1'b0;
        seed_err_d  = 1'b0;
        seed_id_d   = seed_id_q;
        case (state_q)
            IDLE: begin
                if (start && key_ok) begin
                    state_d    = WRITE;
                    seed_id_d  = key_seed;
                    row_addr_d = '0;
                    row_data_d = pattern(key_seed, '0);
                    row_we_d   = 1'b1;
                    busy_d     = 1'b1;
                end else if (start) begin
                    seed_err_d = 1'b1;
                end
            end
            WRITE: begin
                // Without row_ready every write-side output simply holds.
                if (row_ready && last_row) begin
                    state_d     = DONE;
                    row_we_d    = 1'b0;
                    row_data_d  = '0;
                    load_done_d = 1'b1;
                end else if (row_ready) begin
                    row_addr_d = row_addr_q + ROW_W'(1);
                    row_data_d = pattern(seed_id_q, row_addr_q + ROW_W'(1));
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_we_q    <= 1'b0;
            row_addr_q  <= '0;
            row_data_q  <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            seed_err_q  <= 1'b0;
            seed_id_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            row_we_q    <= row_we_d;
            row_addr_q  <= row_addr_d;
            row_data_q  <= row_data_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
            seed_err_q  <= seed_err_d;
            seed_id_q   <= seed_id_d;
        end
    end

    assign row_we    = row_we_q;
    assign row_addr  = row_addr_q;
    assign row_data  = row_data_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;
    assign seed_err  = seed_err_q;
    assign seed_id   = seed_id_q;
endmodule

// File: tb/tb_seed_loader.sv
// tb_seed_loader: directed scenarios for seed_loader with hand-computed row contents.
module tb_seed_loader;
    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int ROW_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       key = 4'b0000;
    logic             key_valid = 1'b0;
    logic             start = 1'b0;
    logic             row_ready = 1'b0;
    logic             row_we;
    logic [ROW_W-1:0] row_addr;
    logic [COLS-1:0]  row_data;
    logic             busy;
    logic             load_done;
    logic             seed_err;
    logic [2:0]       seed_id;

    int               n_checks = 0;
    int               n_fail = 0;
    int               n_wr = 0;
    int               ld_cnt = 0;
    int               wr_addr[64];
    logic [COLS-1:0]  wr_data[64];

    seed_loader #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W)) dut (
        .clk(clk), .reset(reset), .key(key), .key_valid(key_valid), .start(start),
        .row_ready(row_ready), .row_we(row_we), .row_addr(row_addr), .row_data(row_data),
        .busy(busy), .load_done(load_done), .seed_err(seed_err), .seed_id(seed_id)
    );

    always #5 clk = ~clk;

    // Log every accepted write and every cycle load_done is high.
    always @(posedge clk) begin
        if (!reset && row_we && row_ready && n_wr < 64) begin
            wr_addr[n_wr] = int'(row_addr);
            wr_data[n_wr] = row_data;
            n_wr++;
        end
        if (!reset && load_done) ld_cnt++;
    end

    function automatic logic [COLS-1:0] exp_row(input int s, input int r);
        case (s)
            1: return (r == 2) ? 16'h000E : 16'h0000;
            2: return (r == 1) ? 16'h0002 : (r == 2) ? 16'h0004 : (r == 3) ? 16'h0007 : 16'h0000;
            3: return (r == 1 || r == 2) ? 16'h0006 : 16'h0000;
            4: return (r == 3) ? 16'h000C : (r == 4) ? 16'h0006 : (r == 5) ? 16'h0004 : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [3:0] k, input logic v);
        key = k;
        key_valid = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        n_wr = 0;
        ld_cnt = 0;
    endtask

    // Returns the number of edges until load_done is visible, or -1 if the budget runs out.
    task automatic wait_done(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (load_done === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick();
        n_checks++;
        if ({row_we, row_addr, row_data, busy, load_done, seed_err, seed_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%h busy=%b done=%b err=%b id=%0d, expected all 0",
                     row_we, row_addr, row_data, busy, load_done, seed_err, seed_id);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_errors();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        clear_log();
        for (int v = 0; v < 2; v++) begin
            pulse_start(4'b0011, v[0]);
            n_checks++;
            if (seed_err !== 1'b1 || row_we !== 1'b0 || busy !== 1'b0 || seed_id !== 3'd0) begin
                n_fail++;
                $display("FAIL err_pulse_v%0d: got err=%b we=%b busy=%b id=%0d, expected err=1 we=0 busy=0 id=0",
                         v, seed_err, row_we, busy, seed_id);
            end
            tick();
            n_checks++;
            if (seed_err !== 1'b0 || row_we !== 1'b0) begin
                n_fail++;
                $display("FAIL err_one_cycle_v%0d: got err=%b we=%b, expected err=0 we=0", v, seed_err, row_we);
            end
        end
        n_checks++;
        if (n_wr !== 0) begin
            n_fail++;
            $display("FAIL err_no_writes: got %0d writes, expected 0", n_wr);
        end
    endtask

    task automatic test_glider();
        int k;
        clear_log();
        row_ready = 1'b1;
        pulse_start(4'b0010, 1'b1);
        n_checks++;
        if (row_we !== 1'b1 || row_addr !== 4'd0 || busy !== 1'b1 || seed_id !== 3'd2) begin
            n_fail++;
            $display("FAIL glider_first: got we=%b addr=%0d busy=%b id=%0d, expected we=1 addr=0 busy=1 id=2",
                     row_we, row_addr, busy, seed_id);
        end
        wait_done(40, k);
        n_checks++;
        if (k !== ROWS || row_we !== 1'b0) begin
            n_fail++;
            $display("FAIL glider_latency: got load_done after %0d edges (we=%b), expected %0d (we=0)", k, row_we, ROWS);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || load_done !== 1'b0 || seed_id !== 3'd2) begin
            n_fail++;
            $display("FAIL glider_idle: got busy=%b done=%b id=%0d, expected busy=0 done=0 id=2", busy, load_done, seed_id);
        end
        tick();
        n_checks++;
        if (n_wr !== ROWS || ld_cnt !== 1) begin
            n_fail++;
            $display("FAIL glider_counts: got %0d writes %0d dones, expected %0d writes 1 done", n_wr, ld_cnt, ROWS);
        end
        for (int i = 0; i < n_wr && i < ROWS; i++) begin
            n_checks++;
            if (wr_addr[i] !== i || wr_data[i] !== exp_row(2, i)) begin
                n_fail++;
                $display("FAIL glider_row%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                         i, wr_addr[i], wr_data[i], i, exp_row(2, i));
            end
        end
    endtask

    task automatic test_stall();
        int cyc;
        logic rr;
        logic [ROW_W-1:0] pa;
        logic [COLS-1:0] pd;
        clear_log();
        row_ready = 1'b1;
        key = 4'b1000;
        key_valid = 1'b1;
        start = 1'b1;
        row_ready = 1'b0;
        tick();
        start = 1'b0;
        cyc = 0;
        while (load_done !== 1'b1 && cyc < 80) begin
            rr = cyc[0];
            row_ready = rr;
            pa = row_addr;
            pd = row_data;
            tick();
            cyc++;
            if (!rr) begin
                n_checks++;
                if (row_addr !== pa || row_data !== pd || row_we !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_hold_c%0d: got we=%b addr=%0d data=%h, expected we=1 addr=%0d data=%h",
                             cyc, row_we, row_addr, row_data, pa, pd);
                end
            end
        end
        row_ready = 1'b1;
        n_checks++;
        if (load_done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_timeout: got load_done=%b after %0d cycles, expected 1", load_done, cyc);
        end
        tick();
        n_checks++;
        if (n_wr !== ROWS || seed_id !== 3'd4) begin
            n_fail++;
            $display("FAIL stall_count: got %0d writes id=%0d, expected %0d writes id=4", n_wr, seed_id, ROWS);
        end
        for (int i = 0; i < n_wr && i < ROWS; i++) begin
            n_checks++;
            if (wr_addr[i] !== i || wr_data[i] !== exp_row(4, i)) begin
                n_fail++;
                $display("FAIL stall_row%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                         i, wr_addr[i], wr_data[i], i, exp_row(4, i));
            end
        end
    endtask

    task automatic test_ignore_inputs();
        int k;
        clear_log();
        row_ready = 1'b1;
        pulse_start(4'b0001, 1'b1);
        repeat (5) tick();
        n_checks++;
        if (row_addr !== 4'd5) begin
            n_fail++;
            $display("FAIL ignore_addr: got addr=%0d, expected 5", row_addr);
        end
        pulse_start(4'b1000, 1'b1);
        n_checks++;
        if (seed_id !== 3'd1 || row_addr !== 4'd6 || seed_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_write: got id=%0d addr=%0d err=%b, expected id=1 addr=6 err=0", seed_id, row_addr, seed_err);
        end
        wait_done(40, k);
        n_checks++;
        if (k < 0) begin
            n_fail++;
            $display("FAIL ignore_timeout: got no load_done, expected one");
        end
        pulse_start(4'b1000, 1'b1);
        n_checks++;
        if (busy !== 1'b0 || row_we !== 1'b0 || seed_id !== 3'd1) begin
            n_fail++;
            $display("FAIL ignore_start_done: got busy=%b we=%b id=%0d, expected busy=0 we=0 id=1", busy, row_we, seed_id);
        end
        tick();
        tick();
        n_checks++;
        if (n_wr !== ROWS || ld_cnt !== 1 || row_we !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_counts: got %0d writes %0d dones we=%b, expected %0d writes 1 done we=0", n_wr, ld_cnt, row_we, ROWS);
        end
        for (int i = 0; i < n_wr && i < ROWS; i++) begin
            n_checks++;
            if (wr_addr[i] !== i || wr_data[i] !== exp_row(1, i)) begin
                n_fail++;
                $display("FAIL ignore_row%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                         i, wr_addr[i], wr_data[i], i, exp_row(1, i));
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int k;
        clear_log();
        row_ready = 1'b1;
        pulse_start(4'b0010, 1'b1);
        repeat (7) tick();
        n_checks++;
        if (row_addr !== 4'd7 || row_we !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_addr: got addr=%0d we=%b, expected addr=7 we=1", row_addr, row_we);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({row_we, row_addr, row_data, busy, load_done, seed_err, seed_id} !== '0) begin
            n_fail++;
            $display("FAIL midreset_async: got we=%b addr=%0d data=%h busy=%b done=%b id=%0d, expected all 0",
                     row_we, row_addr, row_data, busy, load_done, seed_id);
        end
        tick();
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (ld_cnt !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d dones busy=%b, expected 0 dones busy=0", ld_cnt, busy);
        end
        clear_log();
        pulse_start(4'b0100, 1'b1);
        wait_done(40, k);
        tick();
        n_checks++;
        if (k !== ROWS || n_wr !== ROWS || seed_id !== 3'd3) begin
            n_fail++;
            $display("FAIL midreset_reload: got latency=%0d writes=%0d id=%0d, expected %0d %0d 3", k, n_wr, seed_id, ROWS, ROWS);
        end
        for (int i = 0; i < n_wr && i < ROWS; i++) begin
            n_checks++;
            if (wr_addr[i] !== i || wr_data[i] !== exp_row(3, i)) begin
                n_fail++;
                $display("FAIL midreset_row%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                         i, wr_addr[i], wr_data[i], i, exp_row(3, i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        clear_log();
        row_ready = 1'b1;
        pulse_start(4'b0001, 1'b1);
        wait_done(40, k);
        n_checks++;
        if (k !== ROWS || seed_id !== 3'd1) begin
            n_fail++;
            $display("FAIL b2b_first: got latency=%0d id=%0d, expected %0d id=1", k, seed_id, ROWS);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy=%b, expected 0", busy);
        end
        pulse_start(4'b0100, 1'b1);
        n_checks++;
        if (busy !== 1'b1 || row_we !== 1'b1 || row_addr !== 4'd0 || seed_id !== 3'd3 || row_data !== exp_row(3, 0)) begin
            n_fail++;
            $display("FAIL b2b_second: got busy=%b we=%b addr=%0d id=%0d data=%h, expected busy=1 we=1 addr=0 id=3 data=%h",
                     busy, row_we, row_addr, seed_id, row_data, exp_row(3, 0));
        end
        wait_done(40, k);
        tick();
        n_checks++;
        if (k !== ROWS || n_wr !== 2 * ROWS || ld_cnt !== 2) begin
            n_fail++;
            $display("FAIL b2b_counts: got latency=%0d writes=%0d dones=%0d, expected %0d %0d 2", k, n_wr, ld_cnt, ROWS, 2 * ROWS);
        end
        for (int i = 0; i < ROWS && ROWS + i < n_wr; i++) begin
            n_checks++;
            if (wr_addr[ROWS+i] !== i || wr_data[ROWS+i] !== exp_row(3, i)) begin
                n_fail++;
                $display("FAIL b2b_row%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                         i, wr_addr[ROWS+i], wr_data[ROWS+i], i, exp_row(3, i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_errors();
        test_glider();
        test_stall();
        test_ignore_inputs();
        test_reset_mid_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
